// File: rtl/watch_alert_pkg.sv
// watch_alert_pkg: shared state encoding and alert source codes for the alert scheduler
package watch_alert_pkg;
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ALERT_ALARM = 2'd1,
        ALERT_TIMER = 2'd2,
        SNOOZE      = 2'd3
    } state_t;
    localparam logic [1:0] SRC_NONE  = 2'b00;
    localparam logic [1:0] SRC_ALARM = 2'b01;
    localparam logic [1:0] SRC_TIMER = 2'b10;
endpackage

// File: rtl/beep_pattern_gen.sv
// beep_pattern_gen: free-running on/off beep pattern advanced by tick, restarted high by clr
module beep_pattern_gen #(
    parameter int BEEP_ON  = 25,
    parameter int BEEP_OFF = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic tick,
    output logic beep
);
    localparam int P = BEEP_ON + BEEP_OFF;
    localparam int W = $clog2(P + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (tick) cnt <= (cnt == W'(P - 1)) ? '0 : cnt + 1'b1;
    assign beep = cnt < W'(BEEP_ON);
endmodule

// File: rtl/alert_scheduler.sv
// alert_scheduler: arbitrates alarm/timer alerts onto the shared LED/piezo with ack, timeout, snooze.
// Snooze support is built only when ALERT_SNOOZE_EN is defined.
module alert_scheduler
    import watch_alert_pkg::*;
#(
    parameter int TICK_HZ   = 100,
    parameter int TIMEOUT_S = 60,
    parameter int SNOOZE_S  = 300,
    parameter int BEEP_ON   = 25,
    parameter int BEEP_OFF  = 25
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       tick_100hz,
    input  logic       alarm_en,
    input  logic       alarm_match,
    input  logic       timer_end,
    input  logic       ack_btn,
    input  logic       snooze_btn,
    output logic       alert_active,
    output logic       beep,
    output logic [1:0] alert_src,
    output logic [1:0] pending,
    output logic       snoozing
);
    localparam int SMAX = (TIMEOUT_S > SNOOZE_S) ? TIMEOUT_S : SNOOZE_S;
    localparam int TW   = $clog2(TICK_HZ + 1);
    localparam int SW   = $clog2(SMAX + 1);
    state_t state, state_n;
    logic prev_a, prev_t, prev_k, ev_a, ev_t, ev_k, ev_s;
    logic [1:0] pend, pend_n;
    logic [TW-1:0] tick_cnt;
    logic [SW-1:0] sec_cnt, sec_nx;
    logic wrap, to_hit, sn_hit, req_a, req_t, pa, pt, clr, pat;
`ifdef ALERT_SNOOZE_EN
    logic prev_s;
    always_ff @(posedge clk or negedge rst)
        if (!rst) {prev_s, ev_s} <= '0;
        else {prev_s, ev_s} <= {snooze_btn, snooze_btn & ~prev_s};
    assign snoozing = state == SNOOZE;
`else
    logic unused_snooze;
    assign unused_snooze = snooze_btn;
    assign ev_s = 1'b0;
    assign snoozing = 1'b0;
`endif
    // edge events are registered pulses; a held level never retriggers
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            {prev_a, prev_t, prev_k, ev_a, ev_t, ev_k} <= '0;
            pend <= '0;
            state <= IDLE;
        end else begin
            {prev_a, prev_t, prev_k} <= {alarm_match, timer_end, ack_btn};
            ev_a <= alarm_match & ~prev_a & alarm_en;
            ev_t <= timer_end & ~prev_t;
            ev_k <= ack_btn & ~prev_k;
            pend <= pend_n;
            state <= state_n;
        end
    assign wrap   = tick_100hz && tick_cnt == TW'(TICK_HZ - 1);
    assign sec_nx = (wrap && sec_cnt != SW'(SMAX)) ? sec_cnt + 1'b1 : sec_cnt;
    assign to_hit = sec_nx == SW'(TIMEOUT_S);
    assign sn_hit = sec_nx == SW'(SNOOZE_S);
    // a source that is already being served drops its own new requests
    assign req_a = ev_a & (state == IDLE || state == ALERT_TIMER);
    assign req_t = ev_t & (state != ALERT_TIMER);
    assign pa = pend[0] | req_a;
    assign pt = pend[1] | req_t;
    always_comb begin
        state_n = state;
        pend_n  = {pt, pa};
        case (state)
            IDLE:
                if (pa) begin
                    state_n   = ALERT_ALARM;
                    pend_n[0] = 1'b0;
                end else if (pt) begin
                    state_n   = ALERT_TIMER;
                    pend_n[1] = 1'b0;
                end
            ALERT_ALARM:
                if (!alarm_en) begin
                    state_n   = IDLE;
                    pend_n[0] = 1'b0;
                end else if (ev_k) state_n = IDLE;
                else if (ev_s) state_n = SNOOZE;
                else if (to_hit) state_n = IDLE;
            ALERT_TIMER:
                state_n = (ev_k || to_hit) ? IDLE : ALERT_TIMER;
`ifdef ALERT_SNOOZE_EN
            SNOOZE:
                if (!alarm_en) begin
                    state_n   = IDLE;
                    pend_n[0] = 1'b0;
                end else if (ev_k) state_n = IDLE;
                else if (pt) begin
                    state_n   = ALERT_TIMER;
                    pend_n[1] = 1'b0;
                end else if (sn_hit) state_n = ALERT_ALARM;
`endif
            default: state_n = IDLE;
        endcase
    end
    // every state change restarts the second, tick and beep counters
    assign clr = state_n != state || state == IDLE;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            tick_cnt <= '0;
            sec_cnt  <= '0;
        end else if (clr) begin
            tick_cnt <= '0;
            sec_cnt  <= '0;
        end else begin
            if (tick_100hz) tick_cnt <= wrap ? '0 : tick_cnt + 1'b1;
            sec_cnt <= sec_nx;
        end
    beep_pattern_gen #(.BEEP_ON(BEEP_ON), .BEEP_OFF(BEEP_OFF)) u_beep (
        .clk(clk), .rst(rst), .clr(clr), .tick(tick_100hz), .beep(pat)
    );
    assign alert_active = state == ALERT_ALARM || state == ALERT_TIMER;
    assign beep         = alert_active & pat;
    assign alert_src    = (state == ALERT_TIMER) ? SRC_TIMER : (state == IDLE) ? SRC_NONE : SRC_ALARM;
    assign pending      = pend;
endmodule

// File: tb/tb_alert_scheduler.sv
// tb_alert_scheduler: directed stimulus with a tick-counting reference model checked every cycle
module tb_alert_scheduler;
    localparam int HZ = 4, TO = 3, SN = 2, ON = 2, OFF = 2;
`ifdef ALERT_SNOOZE_EN
    localparam bit SNZ = 1'b1;
`else
    localparam bit SNZ = 1'b0;
`endif
    logic clk, rst, tick_100hz, alarm_en, alarm_match, timer_end, ack_btn, snooze_btn;
    logic alert_active, beep, snoozing;
    logic [1:0] alert_src, pending;
    int n_chk = 0, n_fail = 0, ph = 0;

    alert_scheduler #(.TICK_HZ(HZ), .TIMEOUT_S(TO), .SNOOZE_S(SN), .BEEP_ON(ON), .BEEP_OFF(OFF)) dut (
        .rst(rst), .clk(clk), .tick_100hz(tick_100hz), .alarm_en(alarm_en),
        .alarm_match(alarm_match), .timer_end(timer_end), .ack_btn(ack_btn),
        .snooze_btn(snooze_btn), .alert_active(alert_active), .beep(beep),
        .alert_src(alert_src), .pending(pending), .snoozing(snoozing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // mode: 0 idle, 1 alarm sounding, 2 timer sounding, 3 snoozed; tk = ticks since entering mode
    int mode = 0, tk = 0;
    bit pA, pT, pvA, pvT, pvK, pvS, eA, eT, eK, eS;
    initial forever begin
        @(posedge clk);
        #1;
        if (!rst) begin
            mode = 0; tk = 0;
            {pA, pT, pvA, pvT, pvK, pvS, eA, eT, eK, eS} = '0;
        end else begin
            int nm;
            bit qa, qt;
            qa = pA | (eA && (mode == 0 || mode == 2));
            qt = pT | (eT && mode != 2);
            if (tick_100hz) tk++;
            nm = mode;
            case (mode)
                0: if (qa) begin nm = 1; qa = 0; end else if (qt) begin nm = 2; qt = 0; end
                1: if (!alarm_en) begin nm = 0; qa = 0; end
                   else if (eK) nm = 0;
                   else if (eS && SNZ) nm = 3;
                   else if (tk == TO * HZ) nm = 0;
                2: if (eK || tk == TO * HZ) nm = 0;
                default: if (!alarm_en) begin nm = 0; qa = 0; end
                   else if (eK) nm = 0;
                   else if (qt) begin nm = 2; qt = 0; end
                   else if (tk == SN * HZ) nm = 1;
            endcase
            if (nm != mode) tk = 0;
            mode = nm; pA = qa; pT = qt;
            eA = alarm_match && !pvA && alarm_en;
            eT = timer_end && !pvT;
            eK = ack_btn && !pvK;
            eS = snooze_btn && !pvS;
            {pvA, pvT, pvK, pvS} = {alarm_match, timer_end, ack_btn, snooze_btn};
        end
        chk("m_active", alert_active, (mode == 1 || mode == 2));
        chk("m_src", alert_src, (mode == 3) ? 1 : mode);
        chk("m_beep", beep, (mode == 1 || mode == 2) && (tk % (ON + OFF)) < ON);
        chk("m_pending", pending, {pT, pA});
        chk("m_snoozing", snoozing, mode == 3);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            ph++;
            tick_100hz = (ph % 3 == 0);
        end
    endtask

    task automatic pulse_ack_snz(input bit a, input bit s);
        ack_btn = a; snooze_btn = s;
        cyc(1);
        ack_btn = 0; snooze_btn = 0;
        cyc(1);
    endtask

    // counts ticks seen at clock edges until alert_active equals want; -1 if never
    task automatic count_until(input bit want, output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            bit t;
            t = tick_100hz;
            cyc(1);
            if (t) n++;
            if (alert_active === want) return;
        end
        n = -1;
    endtask

    int n;
    initial begin
        rst = 0; tick_100hz = 0; alarm_en = 0; alarm_match = 0; timer_end = 0;
        ack_btn = 0; snooze_btn = 0;
        cyc(2);
        chk("reset_active", alert_active, 0);
        chk("reset_src", alert_src, 0);
        chk("reset_pending", pending, 0);
        rst = 1;
        cyc(2);
        // alarm then ack; alarm_match stays high afterwards
        alarm_en = 1; alarm_match = 1;
        cyc(1);
        chk("alarm_lat1", alert_active, 0);
        cyc(1);
        chk("alarm_lat2", alert_active, 1);
        chk("alarm_src", alert_src, 1);
        chk("alarm_beep_first", beep, 1);
        cyc(10);
        pulse_ack_snz(1, 0);
        chk("ack_active", alert_active, 0);
        chk("ack_src", alert_src, 0);
        cyc(8);
        chk("held_no_retrig", alert_active, 0);
        alarm_match = 0;
        cyc(2);
        // simultaneous requests: alarm wins, timer queued
        alarm_match = 1; timer_end = 1;
        cyc(2);
        chk("simul_src", alert_src, 1);
        chk("simul_pending", pending, 2);
        pulse_ack_snz(1, 0);
        cyc(1);
        chk("queued_src", alert_src, 2);
        chk("queued_pending", pending, 0);
        // timer left unacknowledged times out
        count_until(0, n);
        chk("timeout_ticks", n, TO * HZ);
        chk("timeout_src", alert_src, 0);
        alarm_match = 0; timer_end = 0;
        cyc(2);
        // snooze
        alarm_match = 1;
        cyc(2);
        chk("snz_pre_active", alert_active, 1);
        pulse_ack_snz(0, 1);
`ifdef ALERT_SNOOZE_EN
        chk("snz_snoozing", snoozing, 1);
        chk("snz_active", alert_active, 0);
        chk("snz_src", alert_src, 1);
        count_until(1, n);
        chk("snz_ticks", n, SN * HZ);
        chk("snz_realert_beep", beep, 1);
        chk("snz_realert_src", alert_src, 1);
`else
        chk("nosnz_snoozing", snoozing, 0);
        chk("nosnz_active", alert_active, 1);
        chk("nosnz_src", alert_src, 1);
`endif
        pulse_ack_snz(1, 0);
        alarm_match = 0;
        cyc(2);
        // ack and snooze together: ack wins
        alarm_match = 1;
        cyc(2);
        pulse_ack_snz(1, 1);
        chk("both_active", alert_active, 0);
        chk("both_snoozing", snoozing, 0);
        alarm_match = 0;
        // snooze during timer alert is ignored
        timer_end = 1;
        cyc(2);
        pulse_ack_snz(0, 1);
        chk("tmr_snz_src", alert_src, 2);
        chk("tmr_snz_active", alert_active, 1);
        // asynchronous reset mid-alert
        #2 rst = 0; timer_end = 0;
        #1;
        chk("arst_active", alert_active, 0);
        chk("arst_src", alert_src, 0);
        chk("arst_beep", beep, 0);
        cyc(2);
        rst = 1;
        cyc(3);
        chk("post_rst_src", alert_src, 0);
        chk("post_rst_pending", pending, 0);
        // alarm_en dropped during alarm alert
        alarm_match = 1;
        cyc(2);
        chk("en_pre_active", alert_active, 1);
        alarm_en = 0;
        cyc(1);
        chk("en_drop_active", alert_active, 0);
        chk("en_drop_pending", pending, 0);
        alarm_match = 0;
        cyc(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alert_scheduler.md
Name: alert_scheduler

Overview:
- Owns the shared alert resources, i.e. the LED pattern driver and the piezo driver.
- Arbitrates between two requesters: the alarm comparator (alarm match) and the countdown timer (timer end).
- Sequences each alert as a beep on/off pattern, with acknowledge, auto-timeout and alarm snooze.
- Replaces the direct OR of the alarm and timer alert signals in the watch top level.

Parameters:
- TICK_HZ, 100: number of tick_100hz pulses per second.
- TIMEOUT_S, 60: seconds an unacknowledged alert sounds before it auto-clears.
- SNOOZE_S, 300: snooze length in seconds.
- BEEP_ON, 25: ticks the beep stays high per period.
- BEEP_OFF, 25: ticks the beep stays low per period.

Ports:
- rst  in  1  asynchronous reset, active-low
- clk  in  1  system clock
- tick_100hz  in  1  one-clk-wide enable pulse at TICK_HZ rate
- alarm_en  in  1  alarm arm switch; 0 blocks new alarm alerts
- alarm_match  in  1  level, high while the current time equals the alarm time
- timer_end  in  1  level, high while the timer sits at zero after expiry
- ack_btn  in  1  acknowledge button, level (already synchronous to clk)
- snooze_btn  in  1  snooze button, level
- alert_active  out  1  enable for led_display and piezo
- beep  out  1  on/off pattern gate for the piezo
- alert_src  out  2  00 none, 01 alarm, 10 timer
- pending  out  2  bit0 alarm queued, bit1 timer queued
- snoozing  out  1  high in the SNOOZE state

Behaviour:
- Reset: all outputs 0; state IDLE; tick, second and beep counters 0; edge registers 0.
- Request capture:
  - Registered rising-edge detect on alarm_match (only counted when alarm_en=1), timer_end, ack_btn and snooze_btn. A request is one clk pulse.
  - A held level never retriggers. Releasing and pressing again is required.
  - Each request event sets its pending bit.
- States:
  - IDLE
  - ALERT_ALARM
  - ALERT_TIMER
  - SNOOZE
- IDLE:
  - If any pending bit is set, go to the ALERT state of the highest-priority pending source. Alarm beats timer.
  - On that transition clear the pending bit, zero the second and beep counters, and set alert_src.
  - Latency from request edge to alert_active=1 is 2 clk: edge register, then the state register.
- ALERT_x:
  - alert_active=1.
  - beep is high for BEEP_ON ticks, then low for BEEP_OFF ticks, repeating. It starts high on the first cycle of the state.
  - A new request for the other source only sets its pending bit. It never pre-empts the current alert.
  - A new request for the same source while that source is active is dropped.
- Exits from ALERT_x, evaluated in this order:
  1. ack edge: go to IDLE.
  2. snooze edge while in ALERT_ALARM: go to SNOOZE.
  3. Seconds count reaches TIMEOUT_S: go to IDLE.
  - Snooze in ALERT_TIMER is ignored.
  - ack and snooze in the same cycle: ack wins.
- SNOOZE:
  - alert_active=0, beep=0, snoozing=1, alert_src=01.
  - After SNOOZE_S seconds go to ALERT_ALARM with counters zeroed.
  - An ack edge goes to IDLE, which cancels the snooze.
  - A pending timer request is served from SNOOZE: go to ALERT_TIMER and drop the snooze. The alarm does not return.
- Leaving any ALERT or SNOOZE state to IDLE sets alert_src=00 on the same edge.
- Seconds counter:
  - Tick counter runs 0..TICK_HZ-1, advancing only on tick_100hz.
  - On wrap it increments the second counter, which saturates at max(TIMEOUT_S, SNOOZE_S).
  - Counter widths are $clog2(param+1).
- alarm_en falling while in ALERT_ALARM or SNOOZE: go to IDLE at once and clear pending[0].
- Asynchronous reset mid-alert: all outputs drop to 0 immediately. The request is lost; no replay.

Optional Feature:
- Macro: ALERT_SNOOZE_EN.
- Defined: SNOOZE state, snooze_btn handling and the snoozing output behave as above.
- Undefined:
  - The SNOOZE state is not built and snooze_btn is ignored.
  - snoozing is tied to 0.
  - SNOOZE_S is unused.

Decomposition:
- Package watch_alert_pkg holds:
  - state encoding: IDLE=2'd0, ALERT_ALARM=2'd1, ALERT_TIMER=2'd2, SNOOZE=2'd3
  - source codes: SRC_NONE, SRC_ALARM, SRC_TIMER
- One sub-module, beep_pattern_gen:
  - Parameters BEEP_ON and BEEP_OFF.
  - Inputs clr and tick; output beep.
  - Free-running on/off tick counter, cleared by clr.

Test Plan:
The bench overrides TICK_HZ=4, TIMEOUT_S=3, SNOOZE_S=2, BEEP_ON=2, BEEP_OFF=2.
- Alarm, then ack: alarm_en=1, rising edge on alarm_match → alert_active=1 and alert_src=01 two clk later; beep toggles every 2 ticks; ack_btn pulse → alert_active=0 and alert_src=00 next clk; holding alarm_match high does not retrigger.
- Simultaneous requests: alarm_match and timer_end rise on the same clk → alert_src=01 and pending=10; after ack → alert_src=10, pending=00.
- Timeout: timer alert left unacknowledged → alert_active falls after exactly 12 ticks (3 s).
- Snooze then re-alert: alarm alert, snooze pulse → snoozing=1 and alert_active=0; after 8 ticks → ALERT_ALARM again with beep high. Repeat with ALERT_SNOOZE_EN undefined → snooze ignored and the alarm keeps sounding.
- Button conflicts: ack and snooze on the same clk in ALERT_ALARM → IDLE. Snooze during ALERT_TIMER → no state change.
- Reset mid-alert: rst low during ALERT_TIMER → all outputs 0 asynchronously; after release, state IDLE and pending=00.
